// File: rtl/des_pkg.sv
// Shared definitions for the DES expansion (E) permutation data path.
//
// Contents:
//   E_BLOCKS, E_IN_W, E_OUT_W, EDGE_W : geometry of the 32->48 expansion
//   half_t      : 32-bit half-block
//   exp_t       : 48-bit E-expanded word (bit 47 = first E output bit)
//   edge_mask_t : one flag per duplicated edge bit (two per 6-bit block)
package des_pkg;

  localparam int E_BLOCKS = 8;
  localparam int E_IN_W   = 32;
  localparam int E_OUT_W  = 48;
  localparam int EDGE_W   = 16;

  typedef logic [E_IN_W-1:0]  half_t;
  typedef logic [E_OUT_W-1:0] exp_t;
  typedef logic [EDGE_W-1:0]  edge_mask_t;

endpackage : des_pkg

// File: rtl/expansion_unpack.sv
// Combinational inverse of the DES expansion permutation E.
//
// Each 6-bit block j of the expanded word carries four core bits
// d[4j..4j+3] framed by two edge bits copied from the neighbouring blocks.
// The half-block is rebuilt from the core bits only; each edge bit is then
// compared against the core bit it duplicates.
//
// Ports:
//   exp_i  : expanded word, bit 47 = first E output bit
//   data_o : recovered 32-bit half-block
//   mask_o : mask[2j]   = left edge of block j disagrees with its source
//            mask[2j+1] = right edge of block j disagrees with its source
module expansion_unpack
  import des_pkg::*;
(
  input  exp_t       exp_i,
  output half_t      data_o,
  output edge_mask_t mask_o
);

  for (genvar j = 0; j < E_BLOCKS; j++) begin : g_block
    for (genvar k = 0; k < 4; k++) begin : g_core
      assign data_o[4*j+k] = exp_i[46-6*j-k];
    end
    // The edge sources wrap around the half-block: block 0's left edge is
    // d[31] and block 7's right edge is d[0].
    assign mask_o[2*j]   = exp_i[47-6*j] ^ data_o[(4*j+31)%32];
    assign mask_o[2*j+1] = exp_i[42-6*j] ^ data_o[(4*j+4)%32];
  end

endmodule : expansion_unpack

// File: rtl/expansion_inverse.sv
// Receive-side inverse of the DES expansion E with edge-bit consistency
// checking, a single output register stage and running error statistics.
//
// Ports:
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   in_valid/ready   : input handshake; in_ready = !out_valid | out_ready
//   in_data          : 48-bit expanded word
//   check_en         : 0 forces the mask of the accepted word to zero
//   out_valid/ready  : output handshake, data held while stalled
//   out_data         : recovered half-block
//   out_err_mask     : edge-bit mismatches of the word in the output register
//   out_err          : OR of out_err_mask
//   clr_stats        : synchronous clear of counters and sticky state
//   word_cnt         : words accepted (saturating)
//   err_cnt          : accepted words with a non-zero mask (saturating)
//   err_sticky       : an errored word has been seen since the last clear
//   first_err_mask   : mask of that first errored word
module expansion_inverse
  import des_pkg::*;
#(
  parameter int CNT_W            = 16,
  parameter bit CHECK_EN_DEFAULT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [47:0]       in_data,
  input  logic              check_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [15:0]       out_err_mask,
  output logic              out_err,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky,
  output logic [15:0]       first_err_mask
);

  half_t      rec_data;
  edge_mask_t raw_mask;
  edge_mask_t gated_mask;
  logic       accept;
  logic       word_err;

  logic       valid_q, valid_d;
  half_t      data_q, data_d;
  edge_mask_t raw_mask_q, raw_mask_d;
  // Check enable that applied to the word held in the output register.
  logic       chk_q, chk_d;

  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             sticky_q, sticky_d;
  edge_mask_t       first_mask_q, first_mask_d;

  expansion_unpack u_unpack (
    .exp_i  (in_data),
    .data_o (rec_data),
    .mask_o (raw_mask)
  );

  assign in_ready   = !valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign gated_mask = check_en ? raw_mask : '0;
  assign word_err   = |gated_mask;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    raw_mask_d = raw_mask_q;
    chk_d      = chk_q;
    if (accept) begin
      valid_d    = 1'b1;
      data_d     = rec_data;
      raw_mask_d = raw_mask;
      chk_d      = check_en;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    word_cnt_d   = word_cnt_q;
    err_cnt_d    = err_cnt_q;
    sticky_d     = sticky_q;
    first_mask_d = first_mask_q;
    if (clr_stats) begin
      word_cnt_d   = '0;
      err_cnt_d    = '0;
      sticky_d     = 1'b0;
      first_mask_d = '0;
    end else if (accept) begin
      if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + CNT_W'(1);
      if (word_err) begin
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (!sticky_q) begin
          sticky_d     = 1'b1;
          first_mask_d = gated_mask;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the data registers are reset too, because the outputs must read
  // zero after reset rather than whatever word was pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      raw_mask_q   <= '0;
      chk_q        <= CHECK_EN_DEFAULT;
      word_cnt_q   <= '0;
      err_cnt_q    <= '0;
      sticky_q     <= 1'b0;
      first_mask_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      raw_mask_q   <= raw_mask_d;
      chk_q        <= chk_d;
      word_cnt_q   <= word_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sticky_q     <= sticky_d;
      first_mask_q <= first_mask_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_err_mask   = chk_q ? raw_mask_q : '0;
  assign out_err        = |out_err_mask;
  assign word_cnt       = word_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_sticky     = sticky_q;
  assign first_err_mask = first_mask_q;

endmodule : expansion_inverse
